// File: rtl/ps2_arrow_decoder.sv
// ps2_arrow_decoder
//   Turns the PS/2 scancode byte stream from PS2_Controller into arrow-key
//   events. Tracks the E0 (extended) and F0 (break) prefixes, keeps a bitmap
//   of held arrow keys, and reports the most recent new press as a
//   registered direction code with a one-cycle strobe.
//
// Ports
//   CLOCK_50          in   system clock, all logic on the rising edge
//   reset             in   synchronous reset, active-high
//   received_data     in   [7:0] byte from PS2_Controller
//   received_data_en  in   one-cycle strobe, received_data valid
//   dir               out  [2:0] last new press: 0 none, 1 up, 2 down, 3 left, 4 right
//   dir_valid         out  one-cycle pulse when dir is loaded by a new press
//   key_held          out  [3:0] held bitmap {right, left, down, up}
//   prefix_timeout    out  one-cycle pulse when a pending prefix is dropped
//
// All outputs are registered; a byte's effect shows one cycle after its strobe.

module ps2_arrow_decoder #(
    parameter int         TIMEOUT_CYCLES = 500000,
    parameter bit         ACCEPT_BASIC   = 1'b1,
    parameter logic [7:0] CODE_UP        = 8'h75,
    parameter logic [7:0] CODE_DOWN      = 8'h72,
    parameter logic [7:0] CODE_LEFT      = 8'h6B,
    parameter logic [7:0] CODE_RIGHT     = 8'h74
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [2:0] dir,
    output logic       dir_valid,
    output logic [3:0] key_held,
    output logic       prefix_timeout
);

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;
    localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer;
    logic          timeout_hit;

    logic          is_arrow;
    logic [1:0]    arrow_idx;
    logic          do_make, do_break;

    logic [2:0]    dir_next;
    logic          dir_valid_next;
    logic [3:0]    key_held_next;

    // A prefix expires only on a cycle with no byte: a coinciding byte wins.
    assign timeout_hit = (state != IDLE) && !received_data_en && (timer == TIMER_LAST);

    // Arrow decode; index matches the key_held bit order {right,left,down,up}.
    always_comb begin
        // NOTE: every signal driven here gets a default first, otherwise paths
        // that skip an assignment would infer a latch.
        is_arrow  = 1'b1;
        arrow_idx = 2'd0;
        if (received_data == CODE_UP)         arrow_idx = 2'd0;
        else if (received_data == CODE_DOWN)  arrow_idx = 2'd1;
        else if (received_data == CODE_LEFT)  arrow_idx = 2'd2;
        else if (received_data == CODE_RIGHT) arrow_idx = 2'd3;
        else                                  is_arrow  = 1'b0;
    end

    // Next-state and make/break decision.
    always_comb begin
        state_next = state;
        do_make    = 1'b0;
        do_break   = 1'b0;
        if (received_data_en) begin
            unique case (state)
                IDLE: begin
                    if (received_data == BYTE_EXT)      state_next = EXT;
                    else if (received_data == BYTE_BRK) state_next = BRK;
                    else                                do_make = is_arrow && ACCEPT_BASIC;
                end
                EXT: begin
                    if (received_data == BYTE_BRK)      state_next = EXT_BRK;
                    else if (received_data == BYTE_EXT) state_next = EXT;
                    else begin
                        state_next = IDLE;
                        do_make    = is_arrow;
                    end
                end
                BRK: begin
                    if (received_data == BYTE_BRK) state_next = BRK;
                    else begin
                        state_next = IDLE;
                        do_break   = is_arrow && ACCEPT_BASIC;
                    end
                end
                EXT_BRK: begin
                    // E0/F0 here are not arrow codes, so they fall out as "other".
                    state_next = IDLE;
                    do_break   = is_arrow;
                end
                default: state_next = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_next = IDLE;
        end
    end

    // Output values for the next cycle.
    always_comb begin
        dir_next       = dir;
        dir_valid_next = 1'b0;
        key_held_next  = key_held;
        if (do_make && !key_held[arrow_idx]) begin
            // Typematic repeats of a held key are ignored.
            key_held_next[arrow_idx] = 1'b1;
            dir_next                 = {1'b0, arrow_idx} + 3'd1;
            dir_valid_next           = 1'b1;
        end
        if (do_break) begin
            key_held_next[arrow_idx] = 1'b0;
        end
    end

    // State, timer and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state          <= IDLE;
            timer          <= '0;
            dir            <= 3'd0;
            dir_valid      <= 1'b0;
            key_held       <= 4'd0;
            prefix_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, so process order cannot change behaviour.
            state          <= state_next;
            dir            <= dir_next;
            dir_valid      <= dir_valid_next;
            key_held       <= key_held_next;
            prefix_timeout <= timeout_hit;
            if (received_data_en || timeout_hit) begin
                timer <= '0;
            end else if (state != IDLE && timer != '1) begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// tb_ps2_arrow_decoder
//   Drives the same directed byte stream into two decoders, one accepting
//   non-extended arrow codes and one requiring the E0 prefix. A prefix-flag
//   model per decoder predicts every output each cycle; literal checks in the
//   stimulus pin the model to hand-computed values.

module tb_ps2_arrow_decoder;

    localparam int T = 20;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;

    logic [2:0] dir_a, dir_b;
    logic       dv_a, dv_b;
    logic [3:0] held_a, held_b;
    logic       to_a, to_b;

    int  tests = 0;
    int  fails = 0;
    bit  cmp_en = 1'b0;

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_arrow_decoder #(.TIMEOUT_CYCLES(T), .ACCEPT_BASIC(1'b1)) dut_a (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .received_data(received_data), .received_data_en(received_data_en),
        .dir(dir_a), .dir_valid(dv_a), .key_held(held_a), .prefix_timeout(to_a)
    );

    ps2_arrow_decoder #(.TIMEOUT_CYCLES(T), .ACCEPT_BASIC(1'b0)) dut_b (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .received_data(received_data), .received_data_en(received_data_en),
        .dir(dir_b), .dir_valid(dv_b), .key_held(held_b), .prefix_timeout(to_b)
    );

    // ---------------- model ----------------
    typedef struct packed {
        bit       ext;     // E0 seen, awaiting code
        bit       brk;     // F0 seen, awaiting code
        int       count;   // idle cycles since the last prefix byte
        bit [2:0] dir;
        bit [3:0] held;
        bit       dv;
        bit       to;
    } model_t;

    model_t m_a = '0;
    model_t m_b = '0;

    function automatic int arrow_of(bit [7:0] b);
        case (b)
            8'h75:   return 0;
            8'h72:   return 1;
            8'h6B:   return 2;
            8'h74:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic model_t model_step(model_t s, bit basic, bit rst, bit en, bit [7:0] b);
        model_t n = s;
        int     k;
        n.dv = 1'b0;
        n.to = 1'b0;
        if (rst) begin
            n = '0;
            return n;
        end
        if (en) begin
            n.count = 0;
            k = arrow_of(b);
            if (b == 8'hE0) begin
                if (!s.brk) n.ext = 1'b1;
                else begin n.ext = 1'b0; n.brk = 1'b0; end
            end else if (b == 8'hF0) begin
                if (!s.brk) n.brk = 1'b1;
                else if (s.ext) begin n.ext = 1'b0; n.brk = 1'b0; end
            end else begin
                n.ext = 1'b0;
                n.brk = 1'b0;
                if (k >= 0 && (s.ext || basic)) begin
                    if (s.brk) n.held[k] = 1'b0;
                    else if (!s.held[k]) begin
                        n.held[k] = 1'b1;
                        n.dir     = 3'(k + 1);
                        n.dv      = 1'b1;
                    end
                end
            end
        end else if (s.ext || s.brk) begin
            if (s.count == T - 1) begin
                n.ext   = 1'b0;
                n.brk   = 1'b0;
                n.count = 0;
                n.to    = 1'b1;
            end else begin
                n.count = s.count + 1;
            end
        end
        return n;
    endfunction

    always @(posedge CLOCK_50) begin
        m_a <= model_step(m_a, 1'b1, reset, received_data_en, received_data);
        m_b <= model_step(m_b, 1'b0, reset, received_data_en, received_data);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (cmp_en) begin
            check("a.dir",            32'(dir_a),  32'(m_a.dir));
            check("a.dir_valid",      32'(dv_a),   32'(m_a.dv));
            check("a.key_held",       32'(held_a), 32'(m_a.held));
            check("a.prefix_timeout", 32'(to_a),   32'(m_a.to));
            check("b.dir",            32'(dir_b),  32'(m_b.dir));
            check("b.dir_valid",      32'(dv_b),   32'(m_b.dv));
            check("b.key_held",       32'(held_b), 32'(m_b.held));
            check("b.prefix_timeout", 32'(to_b),   32'(m_b.to));
        end
    end

    // ---------------- stimulus ----------------
    // Called #1 after a rising edge; returns #1 after the edge that consumed
    // the byte, so the byte's effects are visible on return.
    task automatic send_byte(input logic [7:0] b);
        received_data    = b;
        received_data_en = 1'b1;
        @(posedge CLOCK_50);
        #1;
        received_data_en = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        tick(3);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // 1: reset mid-sequence after E0
        send_byte(8'hE0); send_byte(8'h74);
        check("t1 pre-reset b.dir", 32'(dir_b), 32'd4);
        send_byte(8'hE0);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        check("t1 reset a.dir", 32'(dir_a), 32'd0);
        check("t1 reset a.key_held", 32'(held_a), 32'd0);
        check("t1 reset b.key_held", 32'(held_b), 32'd0);
        check("t1 reset b.prefix_timeout", 32'(to_b), 32'd0);
        send_byte(8'h75);
        check("t1 basic off b.dir_valid", 32'(dv_b), 32'd0);
        check("t1 basic off b.dir", 32'(dir_b), 32'd0);
        check("t1 basic on a.dir", 32'(dir_a), 32'd1);
        send_byte(8'hF0); send_byte(8'h75);
        check("t1 basic break a.key_held", 32'(held_a), 32'd0);

        // 2: E0,75
        tick(2);
        send_byte(8'hE0); send_byte(8'h75);
        check("t2 b.dir", 32'(dir_b), 32'd1);
        check("t2 b.dir_valid", 32'(dv_b), 32'd1);
        check("t2 b.key_held", 32'(held_b), 32'b0001);
        tick(1);
        check("t2 b.dir_valid one cycle", 32'(dv_b), 32'd0);

        // 3: typematic repeat then release
        send_byte(8'hE0); send_byte(8'h75);
        check("t3 repeat b.dir_valid", 32'(dv_b), 32'd0);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        check("t3 release b.key_held", 32'(held_b), 32'd0);
        check("t3 release b.dir", 32'(dir_b), 32'd1);

        // 4: overlapping left and right
        send_byte(8'hE0); send_byte(8'h6B);
        check("t4 left b.dir", 32'(dir_b), 32'd3);
        check("t4 left b.key_held", 32'(held_b), 32'b0100);
        send_byte(8'hE0); send_byte(8'h74);
        check("t4 right b.dir", 32'(dir_b), 32'd4);
        check("t4 right b.key_held", 32'(held_b), 32'b1100);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        check("t4 rel right b.key_held", 32'(held_b), 32'b0100);
        check("t4 rel right b.dir", 32'(dir_b), 32'd4);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);

        // 5: prefix timeout, then basic down
        send_byte(8'hE0);
        for (int i = 1; i < T; i++) begin
            tick(1);
            check("t5 no early timeout", 32'(to_b), 32'd0);
        end
        tick(1);
        check("t5 b.prefix_timeout", 32'(to_b), 32'd1);
        tick(1);
        check("t5 timeout one cycle", 32'(to_b), 32'd0);
        send_byte(8'h72);
        check("t5 basic a.dir", 32'(dir_a), 32'd2);
        check("t5 basic off b.dir", 32'(dir_b), 32'd4);
        send_byte(8'hF0); send_byte(8'h72);

        // byte arriving on the timeout cycle wins
        send_byte(8'hE0);
        tick(T - 1);
        send_byte(8'h75);
        check("coincide b.prefix_timeout", 32'(to_b), 32'd0);
        check("coincide b.dir_valid", 32'(dv_b), 32'd1);
        check("coincide b.dir", 32'(dir_b), 32'd1);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);

        // 6: non-arrow break and controller bytes
        send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hAA); send_byte(8'hFA); send_byte(8'hEE);
        check("t6 b.key_held", 32'(held_b), 32'd0);
        check("t6 b.dir", 32'(dir_b), 32'd1);
        send_byte(8'h75);
        check("t6 basic off b.dir_valid", 32'(dv_b), 32'd0);
        check("t6 basic on a.key_held", 32'(held_a), 32'b0001);
        send_byte(8'hF0); send_byte(8'hF0); send_byte(8'h75);
        check("t6 F0 F0 break a.key_held", 32'(held_a), 32'd0);
        send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h75);
        check("t6 E0 E0 make b.key_held", 32'(held_b), 32'b0001);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h75);
        check("t6 E0 F0 E0 no break b.key_held", 32'(held_b), 32'b0001);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
        check("t6 break unheld b.key_held", 32'(held_b), 32'b0001);

        // timeouts from the break states
        send_byte(8'hF0);
        tick(T + 2);
        send_byte(8'hE0); send_byte(8'hF0);
        tick(T + 2);
        send_byte(8'h75);
        check("t6 stale break ignored b.key_held", 32'(held_b), 32'b0001);
        tick(2);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
